// File: rtl/pad_frame_rx.sv
// ============================================================================
// Module      : pad_frame_rx
// Description : Receives controller-state frames (sync, payload, checksum)
//               from the USB host MCU byte stream and presents a stable,
//               active-low button word to the console serial shifter. The
//               word never changes while the console latch is asserted and
//               reverts to "all released" when the link goes silent.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pad_frame_rx #(
    parameter int          BITS           = 16,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd4800000
) (
    input  logic            system_clock,
    input  logic            reset_n,
    input  logic [7:0]      rx_data,
    input  logic            rx_valid,
    output logic            rx_ready,
    input  logic            latch,
    output logic [BITS-1:0] buttons,
    output logic            frame_ok,
    output logic            frame_err,
    output logic            link_up
);

    localparam int NB    = BITS / 8;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NB - 1);

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2,
        ST_PENDING = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_latch_meta;
    logic               r_latch_s;
    logic [BITS-1:0]    r_shadow;
    logic [BITS-1:0]    w_shadow_shifted;
    logic [IDX_W-1:0]   r_idx;
    logic [7:0]         r_sum;
    logic [23:0]        r_tmo_cnt;
    logic               r_tmo_pend;
    logic [BITS-1:0]    r_buttons;
    logic               r_frame_ok;
    logic               r_frame_err;
    logic               r_link_up;
    logic               w_accept;
    logic               w_start;
    logic               w_load;
    logic               w_commit;
    logic               w_bad;
    logic               w_rx_ready;
    logic               w_tmo_fire;
    logic               w_tmo_apply;

    assign w_accept  = rx_valid && w_rx_ready;
    assign rx_ready  = w_rx_ready;
    assign buttons   = r_buttons;
    assign frame_ok  = r_frame_ok;
    assign frame_err = r_frame_err;
    assign link_up   = r_link_up;

    // Payload bytes shift in from the bottom so the first byte ends up on top.
    generate
        if (BITS == 8) begin : g_shift_single
            assign w_shadow_shifted = rx_data;
        end else begin : g_shift_multi
            assign w_shadow_shifted = {r_shadow[BITS-9:0], rx_data};
        end
    endgenerate

    // Two-flop synchroniser for the console latch (asynchronous domain).
    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_latch_meta <= 1'b0;
            r_latch_s    <= 1'b0;
        end else begin
            r_latch_meta <= latch;
            r_latch_s    <= r_latch_meta;
        end
    end

    // Frame state register.
    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode plus the strobes that steer the datapath.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_load       = 1'b0;
        w_commit     = 1'b0;
        w_bad        = 1'b0;
        w_rx_ready   = 1'b1;
        case (r_state)
            ST_HUNT: begin
                if (w_accept && (rx_data == SYNC_BYTE)) begin
                    w_start      = 1'b1;
                    w_state_next = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                // A sync value here is ordinary payload; no resync attempt.
                if (w_accept) begin
                    w_load = 1'b1;
                    if (r_idx == c_LAST_IDX) begin
                        w_state_next = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (w_accept) begin
                    if (rx_data == r_sum) begin
                        if (r_latch_s) begin
                            w_state_next = ST_PENDING;
                        end else begin
                            w_commit     = 1'b1;
                            w_state_next = ST_HUNT;
                        end
                    end else begin
                        w_bad        = 1'b1;
                        w_state_next = ST_HUNT;
                    end
                end
            end
            ST_PENDING: begin
                // Hold off the byte stream until the shifter has released.
                w_rx_ready = 1'b0;
                if (!r_latch_s) begin
                    w_commit     = 1'b1;
                    w_state_next = ST_HUNT;
                end
            end
            default: begin
                w_state_next = ST_HUNT;
            end
        endcase
    end

    // Shadow word, byte index and running checksum for the frame in flight.
    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_shadow <= '0;
            r_idx    <= '0;
            r_sum    <= 8'h00;
        end else if (w_start) begin
            r_idx <= '0;
            r_sum <= 8'h00;
        end else if (w_load) begin
            r_shadow <= w_shadow_shifted;
            r_idx    <= r_idx + 1'b1;
            r_sum    <= r_sum + rx_data;
        end
    end

    // Expiry happens only on the step into saturation; a commit that same
    // cycle takes precedence. A latched-high expiry is parked until release.
    assign w_tmo_fire  = (r_tmo_cnt == (TIMEOUT_CYCLES - 24'd1));
    assign w_tmo_apply = !w_commit && (w_tmo_fire || r_tmo_pend) && !r_latch_s;

    // Link-silence counter and deferred-expiry flag.
    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tmo_cnt  <= 24'd0;
            r_tmo_pend <= 1'b0;
        end else begin
            if (w_commit) begin
                r_tmo_cnt <= 24'd0;
            end else if (r_tmo_cnt != TIMEOUT_CYCLES) begin
                r_tmo_cnt <= r_tmo_cnt + 24'd1;
            end
            if (w_commit || w_tmo_apply) begin
                r_tmo_pend <= 1'b0;
            end else if (w_tmo_fire && r_latch_s) begin
                r_tmo_pend <= 1'b1;
            end
        end
    end

    // Output word and status: the only writers of the button word.
    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_buttons   <= '1;
            r_link_up   <= 1'b0;
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_ok  <= w_commit;
            r_frame_err <= w_bad;
            if (w_commit) begin
                r_buttons <= r_shadow;
                r_link_up <= 1'b1;
            end else if (w_tmo_apply) begin
                r_buttons <= '1;
                r_link_up <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire
